lite_to_stream_serializer: RTL and testbench
============================================

Name: lite_to_stream_serializer

Overview:
- Converts one wide "lite" memory message (header + full-width data, ready-valid-and) into a stream of narrow beats (ready-valid-and), one beat per out_data_width_p word.
- Each beat carries a copy of the header with an auto-incremented, wrapping address and a last flag.
- Sits between a wide-bus master (cache/IO bridge) and a narrow memory/NoC client.
- Built from a one-entry header/data buffer, a settable beat counter and a last-index register.

Parameters:
- addr_width_p, 40, address field width.
- type_width_p, 4, message type field width.
- size_width_p, 3, log2 of message byte size.
- extra_width_p, 16, opaque header sideband, passed through unchanged.
- in_data_width_p, 512, input data width; a multiple of out_data_width_p.
- out_data_width_p, 64, output beat width; at least 8, multiple of 8.
- payload_mask_p, 0, bit t set means message type t carries data.
- Derived: W = in_data_width_p/out_data_width_p words; OB = out_data_width_p/8; OFS = max(1, clog2(OB)); CW = max(1, clog2(W)).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset.
- in_v_i  in  1  input message valid.
- in_ready_o  out  1  buffer can accept a message.
- in_type_i  in  type_width_p  message type.
- in_size_i  in  size_width_p  log2 bytes.
- in_addr_i  in  addr_width_p  byte address.
- in_extra_i  in  extra_width_p  sideband.
- in_data_i  in  in_data_width_p  payload.
- out_v_o  out  1  beat valid.
- out_ready_i  in  1  client ready.
- out_type_o / out_size_o / out_extra_o  out  as input  buffered header fields.
- out_addr_o  out  addr_width_p  beat address.
- out_data_o  out  out_data_width_p  beat data.
- out_last_o  out  1  final beat of message.

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: asynchronous and active-high. Clears full, beat counter and last register to 0. While reset_i is high, out_v_o=0, out_last_o=0 and in_ready_o=0.
- Accept: occurs when in_v_i & in_ready_o.
  - in_ready_o = ~full. Acceptance is never allowed in the same cycle as a dequeue (no bypass), so at most one message is in flight.
  - On accept, latch the header fields and in_data_i.
  - Set full.
  - Set counter = first = in_addr_i[OFS +: CW].
  - Register last = (first + beats - 1) mod W.
- Beat count: beats = payload_mask_p[in_type_i] ? max((1<<in_size_i)/OB, 1) : 1.
  - Computed with CW+1 bits, clamped to W.
  - Non-payload messages always produce one beat.
- Output:
  - out_v_o = full.
  - Beat k (k = 0..beats-1) drives out_data_o = stored data word k, i.e. bits [k*out_data_width_p +: out_data_width_p]. Word k is independent of the address offset.
  - out_addr_o = {stored addr[addr_width_p-1 : OFS+CW], counter, stored addr[OFS-1:0]}.
  - Other header fields are unchanged.
- Advance: on out_v_o & out_ready_i, counter increments modulo W; this is the wrap-around for critical-word-first addressing.
- out_last_o = out_v_o & (counter == last).
- Dequeue: a handshake with out_last_o high clears full. The next accept is possible one cycle later.
- Holding: if out_ready_i is low, all outputs hold stable.
- Reset mid-message: the message is discarded and no further beats are produced.

Optional Feature:
- Macro: LITE_TO_STREAM_ASSERT_EN.
- When defined (simulation only):
  - Elaboration-time $error if in_data_width_p is not a multiple of out_data_width_p, or if in_data_width_p < out_data_width_p.
  - Runtime $error on an accepted payload message whose (1<<in_size_i) exceeds in_data_width_p/8.
  - Runtime $error if out_v_o drops or out_addr_o changes while the output is stalled.
- When undefined: no checks. Synthesized logic and behaviour are identical either way.

Test Plan (defaults, payload_mask_p = 'b10):
- Reset: assert reset_i asynchronously mid-cycle -> out_v_o=0 immediately; in_ready_o=1 after release.
- Type 0, addr 0x1000, size 3 -> one beat: out_addr_o=0x1000, out_last_o=1; in_ready_o returns to 1 the next cycle.
- Type 1, addr 0x1000, size 6, data words D0..D7, out_ready_i=1 -> 8 beats with addresses 0x1000, 0x1008 … 0x1038 and data D0..D7; out_last_o only on the 8th beat.
- Type 1, addr 0x1030, size 6 -> addresses 0x1030, 0x1038, 0x1000 … 0x1028 (wrap); data D0..D7; last at address 0x1028.
- Type 1, addr 0x1010, size 4 -> 2 beats at 0x1010 and 0x1018 with data D0, D1; last on the 2nd beat.
- Backpressure: toggle out_ready_i every other cycle during an 8-beat message -> outputs stable while stalled; exactly 8 handshakes; in_v_i held high is not accepted until the cycle after the last handshake.

Source files
------------

// File: rtl/lite_to_stream_serializer.sv
// rtl/lite_to_stream_serializer.sv - wide lite message to narrow beat stream serializer
// Optional simulation checks: define LITE_TO_STREAM_ASSERT_EN.
module lite_to_stream_serializer #(
  parameter int addr_width_p     = 40,
  parameter int type_width_p     = 4,
  parameter int size_width_p     = 3,
  parameter int extra_width_p    = 16,
  parameter int in_data_width_p  = 512,
  parameter int out_data_width_p = 64,
  parameter logic [(1<<type_width_p)-1:0] payload_mask_p = '0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        in_v_i,
  output logic                        in_ready_o,
  input  logic [type_width_p-1:0]     in_type_i,
  input  logic [size_width_p-1:0]     in_size_i,
  input  logic [addr_width_p-1:0]     in_addr_i,
  input  logic [extra_width_p-1:0]    in_extra_i,
  input  logic [in_data_width_p-1:0]  in_data_i,
  output logic                        out_v_o,
  input  logic                        out_ready_i,
  output logic [type_width_p-1:0]     out_type_o,
  output logic [size_width_p-1:0]     out_size_o,
  output logic [addr_width_p-1:0]     out_addr_o,
  output logic [extra_width_p-1:0]    out_extra_o,
  output logic [out_data_width_p-1:0] out_data_o,
  output logic                        out_last_o
);

  localparam int unsigned W   = in_data_width_p / out_data_width_p;
  localparam int unsigned OB  = out_data_width_p / 8;
  localparam int          OFS = (OB > 1) ? $clog2(OB) : 1;
  localparam int          CW  = (W > 1) ? $clog2(W) : 1;

  logic                       full_q;
  logic [CW-1:0]              cnt_q, last_q, beat_q;
  logic [CW-1:0]              first_d, last_d, cnt_nxt;
  logic [type_width_p-1:0]    type_q;
  logic [size_width_p-1:0]    size_q;
  logic [addr_width_p-1:0]    addr_q;
  logic [extra_width_p-1:0]   extra_q;
  logic [in_data_width_p-1:0] data_q;
  logic [31:0]                bytes_w, beats_w, first_w, last_w;
  logic                       accept, out_hs;

  assign in_ready_o = ~full_q & ~reset_i;
  assign accept     = in_v_i & in_ready_o;
  assign out_v_o    = full_q;
  assign out_hs     = out_v_o & out_ready_i;
  assign out_last_o = out_v_o & (cnt_q == last_q);

  // Beats from the byte size, clamped to [1, W]; non-payload types are single-beat.
  always_comb begin
    bytes_w = 32'd1 << in_size_i;
    beats_w = 32'd1;
    if (payload_mask_p[in_type_i]) begin
      beats_w = bytes_w / OB;
      if (beats_w == 32'd0) beats_w = 32'd1;
      if (beats_w > W)      beats_w = W;
    end
    first_w = 32'(in_addr_i[OFS +: CW]) % W;
    last_w  = (first_w + beats_w - 32'd1) % W;
    first_d = first_w[CW-1:0];
    last_d  = last_w[CW-1:0];
    cnt_nxt = (32'(cnt_q) == W - 1) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_q <= 1'b0;
      cnt_q  <= '0;
      last_q <= '0;
      beat_q <= '0;
    end else if (accept) begin
      full_q <= 1'b1;
      cnt_q  <= first_d;
      last_q <= last_d;
      beat_q <= '0;
    end else if (out_hs) begin
      cnt_q  <= cnt_nxt;
      beat_q <= beat_q + CW'(1);
      if (out_last_o) full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      type_q  <= in_type_i;
      size_q  <= in_size_i;
      addr_q  <= in_addr_i;
      extra_q <= in_extra_i;
      data_q  <= in_data_i;
    end
  end

  // Data words go out in order; only the address rotates for critical-word-first.
  assign out_data_o  = data_q[beat_q*out_data_width_p +: out_data_width_p];
  assign out_addr_o  = {addr_q[addr_width_p-1:OFS+CW], cnt_q, addr_q[OFS-1:0]};
  assign out_type_o  = type_q;
  assign out_size_o  = size_q;
  assign out_extra_o = extra_q;

`ifdef LITE_TO_STREAM_ASSERT_EN
  if ((in_data_width_p % out_data_width_p) != 0 || in_data_width_p < out_data_width_p) begin : g_bad_width
    $error("lite_to_stream_serializer: in_data_width_p must be a multiple of out_data_width_p");
  end

  logic                    stall_q;
  logic [addr_width_p-1:0] addr_prev_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_q     <= 1'b0;
      addr_prev_q <= '0;
    end else begin
      stall_q     <= out_v_o & ~out_ready_i;
      addr_prev_q <= out_addr_o;
    end
  end

  always @(posedge clk_i) begin
    if (!reset_i) begin
      if (accept && payload_mask_p[in_type_i] && (bytes_w > 32'(in_data_width_p / 8)))
        $error("lite_to_stream_serializer: message size exceeds data width");
      if (stall_q && (!out_v_o || out_addr_o != addr_prev_q))
        $error("lite_to_stream_serializer: output changed while stalled");
    end
  end
`endif

endmodule

// File: tb/tb_lite_to_stream_serializer.sv
// tb/tb_lite_to_stream_serializer.sv - directed self-checking bench for lite_to_stream_serializer
module tb_lite_to_stream_serializer;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         in_v_i = 1'b0;
  logic         in_ready_o;
  logic [3:0]   in_type_i = '0;
  logic [2:0]   in_size_i = '0;
  logic [39:0]  in_addr_i = '0;
  logic [15:0]  in_extra_i = '0;
  logic [511:0] in_data_i = '0;
  logic         out_v_o;
  logic         out_ready_i = 1'b1;
  logic [3:0]   out_type_o;
  logic [2:0]   out_size_o;
  logic [39:0]  out_addr_o;
  logic [15:0]  out_extra_o;
  logic [63:0]  out_data_o;
  logic         out_last_o;

  int n_checks = 0;
  int n_errors = 0;

  lite_to_stream_serializer #(.payload_mask_p(16'b10)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .in_v_i(in_v_i), .in_ready_o(in_ready_o),
    .in_type_i(in_type_i), .in_size_i(in_size_i), .in_addr_i(in_addr_i),
    .in_extra_i(in_extra_i), .in_data_i(in_data_i),
    .out_v_o(out_v_o), .out_ready_i(out_ready_i),
    .out_type_o(out_type_o), .out_size_o(out_size_o), .out_addr_o(out_addr_o),
    .out_extra_o(out_extra_o), .out_data_o(out_data_o), .out_last_o(out_last_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] dword(int k);
    return 64'hC0DE_0000_0000_0000 + 64'(k) * 64'h0101_0101;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a message at a negedge, waits (bounded) for acceptance, then drops in_v_i.
  task automatic send(logic [3:0] t, logic [2:0] s, logic [39:0] a, logic [15:0] x);
    int wait_c;
    @(negedge clk);
    in_type_i = t; in_size_i = s; in_addr_i = a; in_extra_i = x; in_v_i = 1'b1;
    wait_c = 0;
    while (!in_ready_o && wait_c < 20) begin
      @(negedge clk);
      wait_c++;
    end
    check("send_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_v_i = 1'b0;
  endtask

  // Expects n back-to-back beats starting at word offset 'first' of an 8-word line.
  task automatic expect_beats(string tag, logic [39:0] base, int n, int first);
    logic [39:0] ea;
    for (int k = 0; k < n; k++) begin
      ea = (base & ~40'h38) | (40'((first + k) % 8) << 3);
      check({tag, "_v"}, 64'(out_v_o), 64'd1);
      check({tag, "_addr"}, 64'(out_addr_o), 64'(ea));
      check({tag, "_data"}, out_data_o, dword(k));
      check({tag, "_last"}, 64'(out_last_o), 64'(k == n - 1));
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, "_done_v"}, 64'(out_v_o), 64'd0);
    check({tag, "_done_ready"}, 64'(in_ready_o), 64'd1);
  endtask

  initial begin
    int hs;
    for (int k = 0; k < 8; k++) in_data_i[k*64 +: 64] = dword(k);

    // Reset held from time zero
    @(negedge clk);
    check("rst_v", 64'(out_v_o), 64'd0);
    check("rst_last", 64'(out_last_o), 64'd0);
    check("rst_ready", 64'(in_ready_o), 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("rel_ready", 64'(in_ready_o), 64'd1);

    // Non-payload type: single beat, header passed through
    send(4'd0, 3'd3, 40'h1000, 16'hBEEF);
    check("t0_type", 64'(out_type_o), 64'd0);
    check("t0_size", 64'(out_size_o), 64'd3);
    check("t0_extra", 64'(out_extra_o), 64'hBEEF);
    check("t0_ready_busy", 64'(in_ready_o), 64'd0);
    expect_beats("t0", 40'h1000, 1, 0);

    // Full line, aligned
    send(4'd1, 3'd6, 40'h1000, 16'h0001);
    expect_beats("line", 40'h1000, 8, 0);

    // Full line, critical word first with wrap
    send(4'd1, 3'd6, 40'h1030, 16'h0002);
    check("wrap_first_addr", 64'(out_addr_o), 64'h1030);
    expect_beats("wrap", 40'h1030, 8, 6);

    // Two-beat partial message
    send(4'd1, 3'd4, 40'h1010, 16'h0003);
    expect_beats("two", 40'h1010, 2, 2);

    // Payload type smaller than a beat still yields one beat
    send(4'd1, 3'd1, 40'h1022, 16'h0004);
    check("small_addr", 64'(out_addr_o), 64'h1022);
    expect_beats("small", 40'h1022, 1, 4);

    // Backpressure with a second message waiting on in_v_i
    send(4'd1, 3'd6, 40'h1000, 16'h0005);
    in_type_i = 4'd0; in_size_i = 3'd3; in_addr_i = 40'h2000; in_extra_i = 16'h0006; in_v_i = 1'b1;
    hs = 0;
    for (int c = 0; c < 40 && hs < 8; c++) begin
      out_ready_i = (c % 2) == 1;
      check("bp_v", 64'(out_v_o), 64'd1);
      check("bp_addr", 64'(out_addr_o), 64'(40'h1000 + 40'(hs) * 40'd8));
      check("bp_data", out_data_o, dword(hs));
      check("bp_last", 64'(out_last_o), 64'(hs == 7));
      check("bp_ready_busy", 64'(in_ready_o), 64'd0);
      @(posedge clk);
      if (out_ready_i) hs++;
      @(negedge clk);
    end
    check("bp_handshakes", 64'(hs), 64'd8);
    check("bp_after_v", 64'(out_v_o), 64'd0);
    check("bp_after_ready", 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_v_i = 1'b0;
    check("bp_next_v", 64'(out_v_o), 64'd1);
    check("bp_next_addr", 64'(out_addr_o), 64'h2000);
    check("bp_next_extra", 64'(out_extra_o), 64'h0006);
    check("bp_next_last", 64'(out_last_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp_next_done", 64'(out_v_o), 64'd0);

    // Asynchronous reset in the middle of a message
    send(4'd1, 3'd6, 40'h1000, 16'h0007);
    @(posedge clk);
    #2 reset_i = 1'b1;
    #1;
    check("mid_rst_v", 64'(out_v_o), 64'd0);
    check("mid_rst_last", 64'(out_last_o), 64'd0);
    check("mid_rst_ready", 64'(in_ready_o), 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_v", 64'(out_v_o), 64'd0);
      check("post_rst_ready", 64'(in_ready_o), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
